pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 90 +++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// Single pipeline stage with a valid/ready handshake on both sides.
// REG_READY=1 adds a skid entry so in_ready is a pure register output.
module pipe_skid_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_READY  = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Handshake: a beat moves on a rising CLK edge when valid and ready are
  // both high on that side; valid never waits for ready.
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              in_xfer;
  logic              out_xfer;

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = m_valid & out_ready;

  generate
    if (REG_READY != 0) begin : g_skid
      logic              s_valid;
      logic [DATA_W-1:0] s_data;

      assign in_ready  = ~s_valid;
      assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

      always_ff @(posedge CLK) begin
        if (RST || flush) begin
          m_valid <= 1'b0;
          s_valid <= 1'b0;
          if (CLEAR_DATA != 0) begin
            m_data <= '0;
            s_data <= '0;
          end
        end else if (in_xfer) begin
          if (!m_valid || out_xfer) begin
            // Main is free this edge; an older skid entry must go first.
            if (s_valid) begin
              m_data <= s_data;
              s_data <= in_data;
            end else begin
              m_data <= in_data;
            end
            m_valid <= 1'b1;
          end else begin
            s_data  <= in_data;
            s_valid <= 1'b1;
          end
        end else if (out_xfer) begin
          m_valid <= s_valid;
          if (s_valid) begin
            m_data <= s_data;
          end
          s_valid <= 1'b0;
        end
      end
    end else begin : g_single
      assign in_ready  = out_ready | ~m_valid;
      assign occupancy = {1'b0, m_valid};

      always_ff @(posedge CLK) begin
        if (RST || flush) begin
          m_valid <= 1'b0;
          if (CLEAR_DATA != 0) begin
            m_data <= '0;
          end
        end else if (in_xfer) begin
          m_data  <= in_data;
          m_valid <= 1'b1;
        end else if (out_xfer) begin
          m_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
